// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, memory-wait freeze and branch flush.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module id_ex_hazard_stage #(
  parameter int unsigned     DATA_W = 16,
  parameter int unsigned     REG_W  = 4,
  parameter int unsigned     CTRL_W = 12,
  parameter logic [REG_W-1:0] NO_REG = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_src,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_uses_src,
  input  logic              id_uses_dest,
  input  logic [DATA_W-1:0] id_src_val,
  input  logic [DATA_W-1:0] id_dest_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_load,
  input  logic              mem_stall,
  input  logic              ex_flush,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_src,
  output logic [REG_W-1:0]  ex_dest,
  output logic [DATA_W-1:0] ex_src_val,
  output logic [DATA_W-1:0] ex_dest_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_is_load,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {StRun, StBubble, StFreeze} state_e;

  state_e              state_q, state_d;
  logic                ex_valid_q, ex_valid_d;
  logic [REG_W-1:0]    ex_src_q, ex_src_d;
  logic [REG_W-1:0]    ex_dest_q, ex_dest_d;
  logic [DATA_W-1:0]   ex_src_val_q, ex_src_val_d;
  logic [DATA_W-1:0]   ex_dest_val_q, ex_dest_val_d;
  logic [DATA_W-1:0]   ex_imm_q, ex_imm_d;
  logic [CTRL_W-1:0]   ex_ctrl_q, ex_ctrl_d;
  logic                ex_is_load_q, ex_is_load_d;
  logic                hazard;

  always_comb begin
    // In BUBBLE the load has left EX, so no dependency can be seen against it.
    hazard = ex_valid_q & ex_is_load_q & id_valid & (state_q != StBubble) &
             ((id_uses_src & (id_src == ex_dest_q)) | (id_uses_dest & (id_dest == ex_dest_q)));

    state_d       = state_q;
    stall_if_id   = 1'b0;
    ex_valid_d    = ex_valid_q;
    ex_src_d      = ex_src_q;
    ex_dest_d     = ex_dest_q;
    ex_src_val_d  = ex_src_val_q;
    ex_dest_val_d = ex_dest_val_q;
    ex_imm_d      = ex_imm_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_is_load_d  = ex_is_load_q;

    if (rst) begin
      state_d = StRun;
    end else if (ex_flush || (!mem_stall && hazard)) begin
      // Bubble: no real register codes, so forwarding can never match it.
      ex_valid_d    = 1'b0;
      ex_src_d      = NO_REG;
      ex_dest_d     = NO_REG;
      ex_src_val_d  = '0;
      ex_dest_val_d = '0;
      ex_imm_d      = '0;
      ex_ctrl_d     = '0;
      ex_is_load_d  = 1'b0;
      if (ex_flush) begin
        state_d = StRun;
      end else begin
        stall_if_id = 1'b1;
        state_d     = StBubble;
      end
    end else if (mem_stall) begin
      stall_if_id = 1'b1;
      state_d     = StFreeze;
    end else begin
      ex_valid_d    = id_valid;
      ex_src_d      = id_uses_src ? id_src : NO_REG;
      ex_dest_d     = id_uses_dest ? id_dest : NO_REG;
      ex_src_val_d  = id_src_val;
      ex_dest_val_d = id_dest_val;
      ex_imm_d      = id_imm;
      ex_ctrl_d     = id_ctrl;
      ex_is_load_d  = id_is_load;
      state_d       = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      ex_valid_q    <= 1'b0;
      ex_src_q      <= NO_REG;
      ex_dest_q     <= NO_REG;
      ex_src_val_q  <= '0;
      ex_dest_val_q <= '0;
      ex_imm_q      <= '0;
      ex_ctrl_q     <= '0;
      ex_is_load_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ex_valid_q    <= ex_valid_d;
      ex_src_q      <= ex_src_d;
      ex_dest_q     <= ex_dest_d;
      ex_src_val_q  <= ex_src_val_d;
      ex_dest_val_q <= ex_dest_val_d;
      ex_imm_q      <= ex_imm_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_is_load_q  <= ex_is_load_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_src      = ex_src_q;
  assign ex_dest     = ex_dest_q;
  assign ex_src_val  = ex_src_val_q;
  assign ex_dest_val = ex_dest_val_q;
  assign ex_imm      = ex_imm_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_is_load  = ex_is_load_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_id && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed self-checking bench for id_ex_hazard_stage; stats checks follow HAZARD_STATS_EN.
module tb_id_ex_hazard_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_src, id_uses_dest, id_is_load;
  logic [3:0]  id_src, id_dest;
  logic [15:0] id_src_val, id_dest_val, id_imm;
  logic [11:0] id_ctrl;
  logic        mem_stall, ex_flush;
  logic        stall_if_id, ex_valid, ex_is_load;
  logic [3:0]  ex_src, ex_dest;
  logic [15:0] ex_src_val, ex_dest_val, ex_imm, stall_cycles;
  logic [11:0] ex_ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_dest     (id_dest),
    .id_uses_src (id_uses_src),
    .id_uses_dest(id_uses_dest),
    .id_src_val  (id_src_val),
    .id_dest_val (id_dest_val),
    .id_imm      (id_imm),
    .id_ctrl     (id_ctrl),
    .id_is_load  (id_is_load),
    .mem_stall   (mem_stall),
    .ex_flush    (ex_flush),
    .stall_if_id (stall_if_id),
    .ex_valid    (ex_valid),
    .ex_src      (ex_src),
    .ex_dest     (ex_dest),
    .ex_src_val  (ex_src_val),
    .ex_dest_val (ex_dest_val),
    .ex_imm      (ex_imm),
    .ex_ctrl     (ex_ctrl),
    .ex_is_load  (ex_is_load),
    .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] s, input logic us,
                          input logic [3:0] d, input logic ud, input logic ld,
                          input logic [11:0] c, input logic [15:0] sv,
                          input logic [15:0] dv, input logic [15:0] im);
    id_valid = v; id_src = s; id_uses_src = us; id_dest = d; id_uses_dest = ud;
    id_is_load = ld; id_ctrl = c; id_src_val = sv; id_dest_val = dv; id_imm = im;
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b1; ex_flush = 1'b0;
    drive_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 12'hFFF, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    step(); step();
    // Reset values, with mem_stall held high to show it is ignored.
    check("rst_stall", stall_if_id, 0);
    check("rst_valid", ex_valid, 0);
    check("rst_src", ex_src, 4'hF);
    check("rst_dest", ex_dest, 4'hF);
    check("rst_ctrl", ex_ctrl, 0);
    check("rst_imm", ex_imm, 0);
    check("rst_load", ex_is_load, 0);
    check("rst_stats", stall_cycles, 0);

    rst = 1'b0; mem_stall = 1'b0;
    // Load r3 into EX.
    drive_id(1'b1, 4'd1, 1'b1, 4'd3, 1'b1, 1'b1, 12'h0A5, 16'h0101, 16'h0303, 16'h0004);
    step();
    check("ld_dest", ex_dest, 3);
    check("ld_src", ex_src, 1);
    check("ld_isload", ex_is_load, 1);
    check("ld_srcval", ex_src_val, 16'h0101);

    // Load-use on r3: one stall, one bubble, then consumer arrives.
    drive_id(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0, 12'h123, 16'h1111, 16'h2222, 16'h0033);
    #1 check("hz_stall", stall_if_id, 1);
    step();
    check("bub_valid", ex_valid, 0);
    check("bub_src", ex_src, 4'hF);
    check("bub_dest", ex_dest, 4'hF);
    check("bub_ctrl", ex_ctrl, 0);
    check("bub_srcval", ex_src_val, 0);
    check("bub_stall", stall_if_id, 0);
    step();
    check("use_valid", ex_valid, 1);
    check("use_src", ex_src, 3);
    check("use_dest", ex_dest, 4);
    check("use_ctrl", ex_ctrl, 12'h123);
    check("use_imm", ex_imm, 16'h0033);

    // Load r3 again (no source used), then an independent instruction.
    drive_id(1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 12'h0B0, 16'h0, 16'h0, 16'h0);
    step();
    check("ld2_src_noreg", ex_src, 4'hF);
    drive_id(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 12'h556, 16'h5555, 16'h6666, 16'h0077);
    #1 check("indep_stall", stall_if_id, 0);
    step();
    check("indep_src", ex_src, 5);
    check("indep_dest", ex_dest, 6);
    check("indep_dval", ex_dest_val, 16'h6666);

    // Memory wait for 3 cycles: EX holds, IF/ID stalls.
    drive_id(1'b1, 4'd7, 1'b1, 4'd8, 1'b1, 1'b0, 12'h777, 16'h7070, 16'h8080, 16'h0009);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("frz_stall", stall_if_id, 1);
      step();
      check("frz_src", ex_src, 5);
      check("frz_ctrl", ex_ctrl, 12'h556);
    end
    mem_stall = 1'b0;
    #1 check("frz_release", stall_if_id, 0);
    step();
    check("resume_src", ex_src, 7);
    check("resume_ctrl", ex_ctrl, 12'h777);

    // Flush coincident with load-use hazard and mem_stall: flush wins.
    drive_id(1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, 12'h099, 16'h0, 16'h0, 16'h0);
    step();
    drive_id(1'b1, 4'd9, 1'b1, 4'd10, 1'b1, 1'b0, 12'h0AA, 16'h1234, 16'h0, 16'h0);
    ex_flush = 1'b1; mem_stall = 1'b1;
    #1 check("fl_stall", stall_if_id, 0);
    step();
    ex_flush = 1'b0; mem_stall = 1'b0;
    check("fl_valid", ex_valid, 0);
    check("fl_ctrl", ex_ctrl, 0);
    check("fl_dest", ex_dest, 4'hF);
    check("fl_isload", ex_is_load, 0);
    step();
    check("fl_next_src", ex_src, 9);

    // Reset while in BUBBLE.
    drive_id(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 12'h022, 16'h0, 16'h0, 16'h0);
    step();
    drive_id(1'b1, 4'd2, 1'b1, 4'd11, 1'b1, 1'b0, 12'h0BB, 16'h0, 16'h0, 16'h0);
    #1 check("rb_hz_stall", stall_if_id, 1);
    step();
    check("rb_bubble", ex_valid, 0);
    rst = 1'b1;
    #1 check("rb_rst_stall", stall_if_id, 0);
    step();
    rst = 1'b0;
    check("rb_valid", ex_valid, 0);
    check("rb_src", ex_src, 4'hF);
    check("rb_dest", ex_dest, 4'hF);
    #1 check("rb_no_stall", stall_if_id, 0);
    step();
    check("rb_next_valid", ex_valid, 1);
    check("rb_next_src", ex_src, 2);

    // Back-to-back dependent loads: each pair stalls once.
    drive_id(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 12'h0C1, 16'h0, 16'h0, 16'h0);
    step();
    drive_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 12'h0C2, 16'h0, 16'h0, 16'h0);
    #1 check("bb1_stall", stall_if_id, 1);
    step();
    check("bb1_bubble", ex_valid, 0);
    check("bb1_bub_stall", stall_if_id, 0);
    step();
    check("bb_loadB_dest", ex_dest, 3);
    drive_id(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 1'b0, 12'h0C3, 16'h0, 16'h0, 16'h0);
    #1 check("bb2_stall", stall_if_id, 1);
    step();
    check("bb2_bubble", ex_valid, 0);
    step();
    check("bb2_use_src", ex_src, 3);
    check("bb2_use_valid", ex_valid, 1);

`ifdef HAZARD_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("st_clear", stall_cycles, 0);
    for (int i = 0; i < 5; i++) begin
      drive_id(1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1, 12'h001, 16'h0, 16'h0, 16'h0);
      step();
      drive_id(1'b1, 4'd1, 1'b1, 4'd6, 1'b1, 1'b0, 12'h002, 16'h0, 16'h0, 16'h0);
      step();
      step();
    end
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    mem_stall = 1'b0;
    check("st_count9", stall_cycles, 9);
    mem_stall = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    mem_stall = 1'b0;
    check("st_saturate", stall_cycles, 16'hFFFF);
`else
    check("st_tied0", stall_cycles, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

ID/EX pipeline register with integrated load-use hazard detection and stall/flush control. It captures decoded operands and control from the ID stage each cycle and presents them to the EX stage, including the source and destination register codes consumed by the forwarding unit. It inserts exactly one bubble on a load-use dependency. It also freezes on memory wait and squashes its contents on a taken-branch flush.

## Interface
- DATA_W, 16, operand/immediate width
- REG_W, 4, register code width (matches forwarding unit compare width)
- CTRL_W, 12, opaque EX/MEM/WB control bundle width
- NO_REG, 4'hF, register code driven when no register is used; never a real register
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src / id_dest  in  REG_W  source / destination register codes
- id_uses_src / id_uses_dest  in  1  instruction reads that register field
- id_src_val / id_dest_val  in  DATA_W  register file read data
- id_imm  in  DATA_W  immediate
- id_ctrl  in  CTRL_W  control bundle
- id_is_load  in  1  instruction reads memory into id_dest
- mem_stall  in  1  data memory busy; whole pipe freezes
- ex_flush  in  1  taken branch resolved; squash EX-bound instruction
- stall_if_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_src / ex_dest  out  REG_W  to forwarding unit ALU source/dest inputs
- ex_src_val / ex_dest_val / ex_imm  out  DATA_W  registered operands
- ex_ctrl  out  CTRL_W  registered control
- ex_is_load  out  1  registered load flag
- stall_cycles  out  16  stall counter (macro-gated, see Configuration)

## Operation
- States: RUN, BUBBLE, FREEZE. Reset state RUN.
- hazard = ex_valid & ex_is_load & id_valid & ((id_uses_src & id_src==ex_dest) | (id_uses_dest & id_dest==ex_dest)).
- Priority per cycle: rst > ex_flush > mem_stall > hazard > normal load.
- Normal: all ex_* <= id_*; ex_valid <= id_valid; ex_src <= id_uses_src ? id_src : NO_REG; ex_dest likewise; state RUN.
- Hazard: load a bubble (ex_valid=0, ex_ctrl=0, ex_is_load=0, ex_src=ex_dest=NO_REG, data fields 0); stall_if_id=1; state BUBBLE.
- BUBBLE: the bubble occupies EX and the load has moved to MEM. hazard is false because ex_valid=0. Normal load of the held ID instruction; state RUN.
- mem_stall: all ex_* hold; stall_if_id=1; state FREEZE. Leave FREEZE to RUN on the first cycle with mem_stall=0, then evaluate hazard normally.
- ex_flush: load a bubble regardless of hazard or mem_stall; stall_if_id=0; state RUN.
- A bubble never carries a real register code, so forwarding cannot match a squashed instruction.

## Timing
- Latency: id_* sampled at edge N appears on ex_* after edge N.
- stall_if_id is combinational from current ex_* registers, id_* and mem_stall. It is asserted in the same cycle the hazard or mem_stall is present.
- Load-use costs exactly 1 stall cycle. The consumer then reaches EX with the load in WB, and the forwarding unit selects the MEM/WB path.
- Reset values: ex_valid=0, ex_is_load=0, ex_ctrl=0, ex_src=ex_dest=NO_REG, all data 0, stall_if_id=0 (mem_stall ignored during rst), stall_cycles=0, state RUN.
- rst during BUBBLE or FREEZE: the next cycle is RUN with reset values, and no pending stall survives.
- ex_flush and hazard in the same cycle: flush wins, no stall.
- ex_flush and mem_stall in the same cycle: flush wins, state RUN.
- Back-to-back loads with a dependency: each pair stalls independently, 1 cycle each.

## Configuration
- HAZARD_STATS_EN defined: stall_cycles increments by 1 on every cycle with stall_if_id=1 and saturates at 16'hFFFF. It is cleared only by rst.
- HAZARD_STATS_EN undefined: the counter is not built and stall_cycles is tied to 0.

## Test plan
- Load r3 into EX (ex_is_load=1, ex_dest=3), ID add with id_src=3, id_uses_src=1 -> stall_if_id=1 for 1 cycle; next cycle ex_valid=0, ex_src=ex_dest=4'hF; following cycle ex_src=3, ex_valid=1.
- Same load, ID uses only r5 -> no stall; ID fields appear on ex_* after one edge.
- mem_stall high 3 cycles with valid instruction in EX -> ex_* unchanged, stall_if_id=1 for 3 cycles, resumes the cycle after mem_stall drops.
- ex_flush asserted together with a load-use hazard -> stall_if_id=0, next ex_valid=0, ex_ctrl=0, ex_dest=4'hF.
- rst asserted in BUBBLE -> next cycle all outputs at reset values, no extra stall.
- HAZARD_STATS_EN on: 5 hazards plus 4 mem_stall cycles -> stall_cycles=9; force 65540 stall cycles -> holds 16'hFFFF.
